// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline register bus.
// Groups the decode-side inputs (control word, instruction, register data,
// flush/hold) and the EX-side outputs (registered fields, valid, stall,
// bubble counter) of id_ex_pipe.
//   master : decode/test side, drives ID inputs and observes EX outputs
//   slave  : the pipeline register itself
interface id_ex_pipe_if #(
  parameter int unsigned CNT_W = 16
);
  // ID side
  logic [7:0]       ctrl_i;
  logic [31:0]      instr_i;
  logic [31:0]      rs_data_i;
  logic [31:0]      rt_data_i;
  logic             flush_i;
  logic             hold_i;
  // EX side
  logic [7:0]       ex_ctrl_o;
  logic [31:0]      ex_rs_data_o;
  logic [31:0]      ex_rt_data_o;
  logic [31:0]      ex_imm_o;
  logic [4:0]       ex_rs_o;
  logic [4:0]       ex_rt_o;
  logic [4:0]       ex_rd_o;
  logic [5:0]       ex_funct_o;
  logic             ex_valid_o;
  logic             stall_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output ctrl_i, instr_i, rs_data_i, rt_data_i, flush_i, hold_i,
    input  ex_ctrl_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o,
           ex_funct_o, ex_valid_o, stall_o, bubble_cnt_o
  );

  modport slave (
    input  ctrl_i, instr_i, rs_data_i, rt_data_i, flush_i, hold_i,
    output ex_ctrl_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o,
           ex_funct_o, ex_valid_o, stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Latches the decode control word, register data, extended immediate and
// register specifiers into EX; detects load-use hazards (stall_o freezes PC
// and IF/ID while a bubble is inserted); squashes on flush; counts bubbles.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (overrides hold and flush)
//   bus    : id_ex_pipe_if slave (ID inputs, EX outputs, stall, bubble count)
module id_ex_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_pipe_if.slave  bus
);

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        valid;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decode of the instruction sitting in ID
  logic [5:0]  opcode;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [31:0] id_imm;
  logic        use_rt;
  logic        haz;

  assign opcode   = bus.instr_i[31:26];
  assign id_rs    = bus.instr_i[25:21];
  assign id_rt    = bus.instr_i[20:16];
  assign id_rd    = bus.instr_i[15:11];
  assign id_funct = bus.instr_i[5:0];

  // ori is the only zero-extended immediate in this core
  assign id_imm = (opcode == 6'b001101) ? {16'h0000, bus.instr_i[15:0]}
                                        : {{16{bus.instr_i[15]}}, bus.instr_i[15:0]};

  // rt is a source for R-type, sw and beq; for the rest it is a destination
  assign use_rt = (opcode == 6'b000000) || (opcode == 6'b101011) || (opcode == 6'b000100);

  // Load in EX whose destination is read by ID
  assign haz = ex_q.valid && ex_q.ctrl[5] && (ex_q.rt != 5'd0) &&
               ((ex_q.rt == id_rs) || (use_rt && (ex_q.rt == id_rt)));

  // A squashed instruction never needs to wait
  assign bus.stall_o = haz && !bus.flush_i && !rst_i;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!bus.hold_i) begin
      if (bus.flush_i || haz) begin
        // Bubble: everything cleared so forwarding never sees stale specifiers
        ex_d  = '0;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        ex_d.ctrl    = bus.ctrl_i;
        ex_d.rs_data = bus.rs_data_i;
        ex_d.rt_data = bus.rt_data_i;
        ex_d.imm     = id_imm;
        ex_d.rs      = id_rs;
        ex_d.rt      = id_rt;
        ex_d.rd      = id_rd;
        ex_d.funct   = id_funct;
        ex_d.valid   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_ctrl_o    = ex_q.ctrl;
  assign bus.ex_rs_data_o = ex_q.rs_data;
  assign bus.ex_rt_data_o = ex_q.rt_data;
  assign bus.ex_imm_o     = ex_q.imm;
  assign bus.ex_rs_o      = ex_q.rs;
  assign bus.ex_rt_o      = ex_q.rt;
  assign bus.ex_rd_o      = ex_q.rd;
  assign bus.ex_funct_o   = ex_q.funct;
  assign bus.ex_valid_o   = ex_q.valid;
  assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 3;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_ex_pipe_if #(.CNT_W(CNT_W)) bus ();
  id_ex_pipe_if #(.CNT_W(SAT_W)) sbus ();

  id_ex_pipe #(.CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Narrow counter instance for the saturation check
  id_ex_pipe #(.CNT_W(SAT_W)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sbus)
  );

  typedef struct packed {
    logic [7:0]       ctrl;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic [31:0]      imm;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [5:0]       funct;
    logic             valid;
    logic [CNT_W-1:0] cnt;
  } ex_t;

  int   checks   = 0;
  int   failures = 0;
  ex_t  m;          // reference model of EX state
  ex_t  exp_q[$];   // scoreboard

  function automatic ex_t observe();
    ex_t o;
    o.ctrl    = bus.ex_ctrl_o;
    o.rs_data = bus.ex_rs_data_o;
    o.rt_data = bus.ex_rt_data_o;
    o.imm     = bus.ex_imm_o;
    o.rs      = bus.ex_rs_o;
    o.rt      = bus.ex_rt_o;
    o.rd      = bus.ex_rd_o;
    o.funct   = bus.ex_funct_o;
    o.valid   = bus.ex_valid_o;
    o.cnt     = bus.bubble_cnt_o;
    return o;
  endfunction

  function automatic logic model_haz(ex_t cur, logic [31:0] instr);
    logic [5:0] op;
    logic       src_rt;
    op     = instr[31:26];
    src_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return cur.valid & cur.ctrl[5] & (cur.rt != 0) &
           ((cur.rt == instr[25:21]) | (src_rt & (cur.rt == instr[20:16])));
  endfunction

  function automatic ex_t model_next(ex_t cur, logic r, logic [7:0] ctrl, logic [31:0] instr,
                                     logic [31:0] rsd, logic [31:0] rtd, logic fl, logic hd);
    ex_t n;
    n = cur;
    if (r) begin
      n = '0;
    end else if (hd) begin
      n = cur;
    end else if (fl || model_haz(cur, instr)) begin
      n     = '0;
      n.cnt = (cur.cnt == {CNT_W{1'b1}}) ? cur.cnt : cur.cnt + 1'b1;
    end else begin
      n.ctrl    = ctrl;
      n.rs_data = rsd;
      n.rt_data = rtd;
      n.imm     = (instr[31:26] == 6'h0D) ? {16'h0, instr[15:0]}
                                          : {{16{instr[15]}}, instr[15:0]};
      n.rs      = instr[25:21];
      n.rt      = instr[20:16];
      n.rd      = instr[15:11];
      n.funct   = instr[5:0];
      n.valid   = 1'b1;
    end
    return n;
  endfunction

  // One clock: drive ID, check stall, push expected EX, clock, pop and compare.
  task automatic step(input string tag, input logic r, input logic [7:0] ctrl,
                      input logic [31:0] instr, input logic fl, input logic hd);
    logic  exp_stall;
    ex_t   e;
    ex_t   o;
    logic [31:0] rsd;
    logic [31:0] rtd;
    rsd = $urandom;
    rtd = $urandom;
    rst           = r;
    bus.ctrl_i    = ctrl;
    bus.instr_i   = instr;
    bus.rs_data_i = rsd;
    bus.rt_data_i = rtd;
    bus.flush_i   = fl;
    bus.hold_i    = hd;
    #1;
    exp_stall = model_haz(m, instr) & ~fl & ~r;
    checks++;
    assert (bus.stall_o === exp_stall) else begin
      failures++;
      $error("FAIL %s_stall observed=%b expected=%b", tag, bus.stall_o, exp_stall);
    end
    m = model_next(m, r, ctrl, instr, rsd, rtd, fl, hd);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = observe();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s_ex observed=%h expected=%h", tag, o, e);
    end
  endtask

  localparam logic [31:0] I_ADDI  = 32'h2128FFFC; // addi $8,$9,-4
  localparam logic [31:0] I_ORI   = 32'h3528F000; // ori  $8,$9,0xF000
  localparam logic [31:0] I_LW8   = 32'h8D280000; // lw   $8,0($9)
  localparam logic [31:0] I_ADD   = 32'h01095020; // add  $10,$8,$9
  localparam logic [31:0] I_LW0   = 32'h8C000000; // lw   $0,0($0)
  localparam logic [31:0] I_ADD0  = 32'h00005020; // add  $10,$0,$0
  localparam logic [31:0] I_ADDI8 = 32'h20680001; // addi $8,$3,1
  localparam logic [31:0] I_SW    = 32'hAC480004; // sw   $8,4($2)
  localparam logic [31:0] I_LWD   = 32'h8C680000; // lw   $8,0($3)
  localparam logic [31:0] I_J     = 32'h08000010; // j    0x40

  initial begin
    logic [SAT_W-1:0] sat_exp;
    ex_t o;

    rst = 1'b1;
    bus.ctrl_i = '0;  bus.instr_i = '0;  bus.rs_data_i = '0;  bus.rt_data_i = '0;
    bus.flush_i = 1'b0;  bus.hold_i = 1'b0;
    sbus.ctrl_i = '0; sbus.instr_i = '0; sbus.rs_data_i = '0; sbus.rt_data_i = '0;
    sbus.flush_i = 1'b0; sbus.hold_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m = '0;
    o = observe();
    checks++;
    assert (o === m) else begin
      failures++;
      $error("FAIL reset_init observed=%h expected=%h", o, m);
    end

    // Normal loads and immediate extension
    step("addi",        1'b0, 8'h8C, I_ADDI,  1'b0, 1'b0);
    step("ori",         1'b0, 8'h88, I_ORI,   1'b0, 1'b0);
    // Reset mid-stream wins over a pending load
    step("addi_pre",    1'b0, 8'h8C, I_ADDI,  1'b0, 1'b0);
    step("reset_mid",   1'b1, 8'h8C, I_ADDI,  1'b1, 1'b1);
    // Load-use: one bubble, then the consumer advances
    step("lw8",         1'b0, 8'hEC, I_LW8,   1'b0, 1'b0);
    step("loaduse",     1'b0, 8'h82, I_ADD,   1'b0, 1'b0);
    step("loaduse_go",  1'b0, 8'h82, I_ADD,   1'b0, 1'b0);
    // No false hazards
    step("lw0",         1'b0, 8'hEC, I_LW0,   1'b0, 1'b0);
    step("rs_zero",     1'b0, 8'h82, I_ADD0,  1'b0, 1'b0);
    step("lw8_b",       1'b0, 8'hEC, I_LW8,   1'b0, 1'b0);
    step("rt_dest",     1'b0, 8'h8C, I_ADDI8, 1'b0, 1'b0);
    step("lw8_c",       1'b0, 8'hEC, I_LW8,   1'b0, 1'b0);
    step("lw_dest",     1'b0, 8'hEC, I_LWD,   1'b0, 1'b0);
    // sw uses rt as a source
    step("sw_haz",      1'b0, 8'h18, I_SW,    1'b0, 1'b0);
    step("sw_go",       1'b0, 8'h18, I_SW,    1'b0, 1'b0);
    // Flush together with hazard: one bubble, no stall
    step("lw8_d",       1'b0, 8'hEC, I_LW8,   1'b0, 1'b0);
    step("flush_haz",   1'b0, 8'h82, I_ADD,   1'b1, 1'b0);
    // Hold with hazard pending: stall stays high, EX frozen
    step("lw8_e",       1'b0, 8'hEC, I_LW8,   1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_haz", 1'b0, 8'h82, I_ADD, 1'b0, 1'b1);
    step("hold_rel",    1'b0, 8'h82, I_ADD,   1'b0, 1'b0);
    step("add_go",      1'b0, 8'h82, I_ADD,   1'b0, 1'b0);
    // Jump loads normally; following instruction squashed
    step("jump",        1'b0, 8'h00, I_J,     1'b0, 1'b0);
    step("jump_squash", 1'b0, 8'h8C, I_ADDI,  1'b1, 1'b0);
    // Hold over a flush leaves the counter alone
    for (int i = 0; i < 3; i++) step("hold_flush", 1'b0, 8'h8C, I_ADDI, 1'b1, 1'b1);

    // Saturation on the narrow instance
    sat_exp = '0;
    checks++;
    assert (sbus.bubble_cnt_o === sat_exp) else begin
      failures++;
      $error("FAIL sat_start observed=%h expected=%h", sbus.bubble_cnt_o, sat_exp);
    end
    sbus.flush_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (sat_exp != {SAT_W{1'b1}}) sat_exp = sat_exp + 1'b1;
      checks++;
      assert (sbus.bubble_cnt_o === sat_exp) else begin
        failures++;
        $error("FAIL sat_cnt observed=%h expected=%h", sbus.bubble_cnt_o, sat_exp);
      end
    end
    sbus.flush_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the instruction-decode Control unit.
- Latches the 8-bit control word, register-file read data, extended immediate and register specifiers into EX.
- Performs load-use hazard detection. On a hazard it stalls PC and IF/ID, then inserts a bubble.
- Applies pipeline flush for taken branches and jumps, and counts inserted bubbles.

Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- ctrl_i  in  8  ID control word: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite, [3] ALUSrc, [2:1] ALUOp, [0] RegDst
- instr_i  in  32  ID instruction
- rs_data_i  in  32  register-file read data for rs
- rt_data_i  in  32  register-file read data for rt
- flush_i  in  1  squash the ID instruction (taken beq or jump)
- hold_i  in  1  global freeze (memory wait); EX contents hold
- ex_ctrl_o  out  8  registered control word
- ex_rs_data_o  out  32  registered rs data
- ex_rt_data_o  out  32  registered rt data
- ex_imm_o  out  32  registered extended immediate
- ex_rs_o  out  5  registered rs specifier
- ex_rt_o  out  5  registered rt specifier
- ex_rd_o  out  5  registered rd specifier
- ex_funct_o  out  6  registered funct field
- ex_valid_o  out  1  EX holds a real (non-bubble) instruction
- stall_o  out  1  combinational; deasserts PC write and IF/ID write
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_i=1 at clock edge): all ex_* outputs go to 0, ex_valid_o=0, bubble_cnt_o=0. Reset overrides hold_i and flush_i.
- Field extraction from instr_i:
  - rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
  - Immediate is zero-extended when opcode=001101 (ori); otherwise it is sign-extended from [15:0].
- Hazard detection (combinational):
  - haz = ex_valid_o & ex_ctrl_o[5] & (ex_rt_o != 0) & ((ex_rt_o == rs) | (use_rt & ex_rt_o == rt)).
  - use_rt = 1 when opcode is 000000, 101011 or 000100; 0 otherwise.
- stall_o = haz & ~flush_i & ~rst_i. A squashed instruction never stalls. hold_i does not mask stall_o.
- Per-edge update priority (highest first):
  1. rst_i: reset values as above.
  2. hold_i: all registers keep their values; bubble_cnt_o is unchanged.
  3. flush_i: load a bubble; bubble_cnt_o += 1.
  4. haz: load a bubble; bubble_cnt_o += 1.
  5. Otherwise: load all fields from ID; ex_ctrl_o = ctrl_i; ex_valid_o = 1.
- Bubble definition: ex_ctrl_o = 0 and ex_valid_o = 0. All data and specifier registers also load 0, so there are no stale specifiers for forwarding.
- Latency: one cycle from ID inputs to ex_* outputs. A load-use pair costs exactly one bubble. On the following cycle EX holds the bubble, so haz=0 and the stalled instruction advances.
- bubble_cnt_o saturates at all-ones and does not wrap.
- Jumps carry control word 0 and are loaded as normal with ex_valid_o=1. Squashing the following instruction is flush_i's job.
- Simultaneous events:
  - flush_i and haz together: one flush bubble, stall_o=0, counter +1 (not +2).
  - hold_i and haz together: stall_o=1, EX unchanged.

Test Plan:
- Reset mid-stream: load addi (ctrl 8'h8C), assert rst_i for one edge -> next cycle all ex_* = 0, ex_valid_o=0, bubble_cnt_o=0.
- Normal load: instr 32'h2128FFFC (addi $8,$9,-4), ctrl 8'h8C -> next edge: ex_ctrl_o=8'h8C, ex_imm_o=32'hFFFFFFFC, ex_rs_o=9, ex_rt_o=8, ex_valid_o=1, stall_o=0.
- ori extension: instr 32'h3528F000 -> ex_imm_o=32'h0000F000.
- Load-use: EX holds lw $8 (ctrl 8'hEC); ID holds add $10,$8,$9 -> stall_o=1 this cycle; next edge ex_ctrl_o=0, ex_valid_o=0, bubble_cnt_o=1; following edge add loads with stall_o=0.
- No false hazards:
  - lw $0 in EX with ID rs=0 -> stall_o=0.
  - lw $8 in EX, ID is addi $8,$3,1 (rt is a destination) -> stall_o=0.
- Flush/hold interaction:
  - flush_i together with haz -> stall_o=0, one bubble, counter +1.
  - hold_i for 3 cycles -> ex_* and bubble_cnt_o unchanged.
  - Force counter to 16'hFFFF, then flush -> stays 16'hFFFF.
